// File: rtl/demux7_reg.sv
// demux7_reg: 1-to-7 registered demultiplexer with per-channel valid/ready.
// Each channel is a one-entry holding register. A word offered on
// w_demuxIn is steered to the channel named by demuxFlag; 3'b111 is an
// illegal select whose word is always accepted and dropped.
// Optional feature macro: DEMUX7_ERR_EN adds a sticky illegal-select flag
// (err) with its clear input (err_clr).

// One output channel: holds a single word plus its valid bit.
module demux7_chan #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);

    // Load wins over drain so a same-cycle refill leaves no bubble.
    // Data is kept after drain; only vld says whether it is live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld  <= 1'b0;
            dout <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            dout <= din;
        end else if (take) begin
            vld  <= 1'b0;
        end
    end

endmodule

module demux7_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       demuxFlag,
    input  logic [WIDTH-1:0] w_demuxIn,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] w_demuxOut0,
    output logic [WIDTH-1:0] w_demuxOut1,
    output logic [WIDTH-1:0] w_demuxOut2,
    output logic [WIDTH-1:0] w_demuxOut3,
    output logic [WIDTH-1:0] w_demuxOut4,
    output logic [WIDTH-1:0] w_demuxOut5,
    output logic [WIDTH-1:0] w_demuxOut6,
    output logic [6:0]       out_valid,
    input  logic [6:0]       out_ready
`ifdef DEMUX7_ERR_EN
    ,
    input  logic             err_clr,
    output logic             err
`endif
);

    localparam int NUM_LANES = 7;

    // Offered transfer, bundled for readability.
    typedef struct packed {
        logic             vld;
        logic [2:0]       sel;
        logic [WIDTH-1:0] data;
    } req_t;

    req_t                              req;
    logic                              legal;
    logic                              accept;
    logic [NUM_LANES-1:0]              sel;
    logic [NUM_LANES-1:0]              laneRdy;
    logic [NUM_LANES-1:0]              load;
    logic [NUM_LANES-1:0]              take;
    logic [NUM_LANES-1:0][WIDTH-1:0]   laneData;

    assign req   = '{vld: in_valid, sel: demuxFlag, data: w_demuxIn};
    assign legal = (req.sel != 3'b111);

    // One-hot channel decode and per-channel space check. A lane has room
    // when it is empty or its consumer drains it this same cycle.
    for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
        assign sel[k]     = legal && (req.sel == 3'(k));
        assign laneRdy[k] = !out_valid[k] || out_ready[k];
    end

    // Illegal selects are always taken so the producer never stalls on them;
    // ready never looks at in_valid.
    assign in_ready = legal ? |(sel & laneRdy) : 1'b1;
    assign accept   = req.vld && in_ready;
    assign load     = accept ? sel : '0;
    assign take     = out_valid & out_ready;

    demux7_chan #(.WIDTH(WIDTH)) uChan [NUM_LANES-1:0] (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .take  (take),
        .din   (req.data),
        .dout  (laneData),
        .vld   (out_valid)
    );

    assign w_demuxOut0 = laneData[0];
    assign w_demuxOut1 = laneData[1];
    assign w_demuxOut2 = laneData[2];
    assign w_demuxOut3 = laneData[3];
    assign w_demuxOut4 = laneData[4];
    assign w_demuxOut5 = laneData[5];
    assign w_demuxOut6 = laneData[6];

`ifdef DEMUX7_ERR_EN
    logic illegalAcc;
    assign illegalAcc = accept && !legal;

    // Sticky error on any accepted illegal word; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           err <= 1'b0;
        else if (err_clr)    err <= 1'b0;
        else if (illegalAcc) err <= 1'b1;
    end
`endif

endmodule
